// File: rtl/color_centroid_calc.sv
// ---------------------------------------------------------------------------
// color_centroid_calc
//   Per-frame centroid of pixels flagged as the target colour. Hit pixels
//   are accumulated during active video. On each frame end (rising VtcVs)
//   the sums are snapshotted and divided by the hit count with a serial
//   restoring divider, then center_h/center_v are published.
//
// Optional feature macro: WEIGHTED_CENTROID_EN
//   defined   : each hit contributes its 4-bit 'weight' input
//   undefined : each hit contributes 1 ('weight' is ignored)
//
// Ports
//   PCLK          pixel clock
//   RST_N         asynchronous active-low reset
//   VtcHCnt       pixel x coordinate (12 bits)
//   VtcVCnt       pixel y coordinate (11 bits)
//   VtcVde        active-video qualifier
//   VtcVs         vertical sync, active high; rising edge ends a frame
//   pix_hit       pixel matches the target colour
//   weight        pixel weight (optional feature only)
//   center_h      registered centroid x
//   center_v      registered centroid y
//   center_valid  last completed frame reached MIN_PIXELS
//   pixel_count   count (or weight sum) of the last completed frame
//   overrun       sticky: frame end arrived while the divider was busy
// ---------------------------------------------------------------------------
module color_centroid_calc #(
    parameter int unsigned SUM_W        = 32,
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned MIN_PIXELS   = 16,
    parameter int unsigned CENTER_H_RST = 160,
    parameter int unsigned CENTER_V_RST = 120
) (
    input  logic             PCLK,
    input  logic             RST_N,
    input  logic [11:0]      VtcHCnt,
    input  logic [10:0]      VtcVCnt,
    input  logic             VtcVde,
    input  logic             VtcVs,
    input  logic             pix_hit,
    input  logic [3:0]       weight,
    output logic [11:0]      center_h,
    output logic [10:0]      center_v,
    output logic             center_valid,
    output logic [CNT_W-1:0] pixel_count,
    output logic             overrun
);

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_CHECK,
        ST_DIV_X,
        ST_DIV_Y,
        ST_UPDATE
    } state_t;

    localparam int unsigned     BIT_W    = $clog2(SUM_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);

    state_t           state_q;
    logic             vs_q;
    logic [SUM_W-1:0] sum_x_q, sum_x_d;
    logic [SUM_W-1:0] sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] snap_x_q, snap_y_q;
    logic [CNT_W-1:0] snap_cnt_q;
    logic [SUM_W-1:0] div_rem_q, div_rem_d;
    logic [SUM_W-1:0] div_quo_q, div_quo_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [11:0]      quo_x_q;
    logic [11:0]      center_h_q;
    logic [10:0]      center_v_q;
    logic             center_valid_q;
    logic [CNT_W-1:0] pixel_count_q;
    logic             overrun_q;

    logic [3:0]       w;
    logic             frame_end;
    logic [SUM_W:0]   div_shift;
    logic [SUM_W:0]   div_trial;

`ifdef WEIGHTED_CENTROID_EN
    always_comb w = weight;
`else
    logic weight_unused;
    always_comb w = 4'd1;
    always_comb weight_unused = ^weight;
`endif

    always_comb frame_end = VtcVs & ~vs_q;

    // Live accumulators; a hit on the frame-end cycle is dropped.
    always_comb begin
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        if (frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else if (VtcVde && pix_hit) begin
            sum_x_d = sum_x_q + SUM_W'(VtcHCnt) * SUM_W'(w);
            sum_y_d = sum_y_q + SUM_W'(VtcVCnt) * SUM_W'(w);
            cnt_d   = cnt_q + CNT_W'(w);
        end
    end

    // One restoring-division step. The remainder stays below the divisor,
    // so bit SUM_W of the trial difference is a reliable borrow flag.
    always_comb begin
        div_shift = {div_rem_q, div_quo_q[SUM_W-1]};
        div_trial = div_shift - {{(SUM_W + 1 - CNT_W){1'b0}}, snap_cnt_q};
        if (!div_trial[SUM_W]) begin
            div_rem_d = div_trial[SUM_W-1:0];
            div_quo_d = {div_quo_q[SUM_W-2:0], 1'b1};
        end else begin
            div_rem_d = div_shift[SUM_W-1:0];
            div_quo_d = {div_quo_q[SUM_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_ACCUM;
            vs_q           <= 1'b0;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            cnt_q          <= '0;
            snap_x_q       <= '0;
            snap_y_q       <= '0;
            snap_cnt_q     <= '0;
            div_rem_q      <= '0;
            div_quo_q      <= '0;
            bit_cnt_q      <= '0;
            quo_x_q        <= '0;
            center_h_q     <= 12'(CENTER_H_RST);
            center_v_q     <= 11'(CENTER_V_RST);
            center_valid_q <= 1'b0;
            pixel_count_q  <= '0;
            overrun_q      <= 1'b0;
        end else begin
            vs_q    <= VtcVs;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
            // Frame end while busy: data already discarded by the clear above.
            if (frame_end && state_q != ST_ACCUM) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_ACCUM: begin
                    if (frame_end) begin
                        snap_x_q   <= sum_x_q;
                        snap_y_q   <= sum_y_q;
                        snap_cnt_q <= cnt_q;
                        state_q    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (snap_cnt_q < MIN_CNT) begin
                        center_valid_q <= 1'b0;
                        pixel_count_q  <= snap_cnt_q;
                        state_q        <= ST_ACCUM;
                    end else begin
                        div_rem_q <= '0;
                        div_quo_q <= snap_x_q;
                        bit_cnt_q <= '0;
                        state_q   <= ST_DIV_X;
                    end
                end
                ST_DIV_X: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        quo_x_q   <= div_quo_d[11:0];
                        div_rem_q <= '0;
                        div_quo_q <= snap_y_q;
                        bit_cnt_q <= '0;
                        state_q   <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    center_h_q     <= quo_x_q;
                    center_v_q     <= div_quo_q[10:0];
                    center_valid_q <= 1'b1;
                    pixel_count_q  <= snap_cnt_q;
                    state_q        <= ST_ACCUM;
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        center_h     = center_h_q;
        center_v     = center_v_q;
        center_valid = center_valid_q;
        pixel_count  = pixel_count_q;
        overrun      = overrun_q;
    end

endmodule

// File: tb/tb_color_centroid_calc.sv
module tb_color_centroid_calc;

    logic        PCLK    = 1'b0;
    logic        RST_N   = 1'b0;
    logic [11:0] VtcHCnt = '0;
    logic [10:0] VtcVCnt = '0;
    logic        VtcVde  = 1'b0;
    logic        VtcVs   = 1'b0;
    logic        pix_hit = 1'b0;
    logic [3:0]  weight  = '0;

    // u_dut: MIN_PIXELS=16, u_dut1: MIN_PIXELS=1; both see identical stimulus
    logic [11:0] center_h,  center_h1;
    logic [10:0] center_v,  center_v1;
    logic        center_valid, center_valid1;
    logic [23:0] pixel_count, pixel_count1;
    logic        overrun, overrun1;

    color_centroid_calc #(.MIN_PIXELS(16)) u_dut (
        .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .VtcVde(VtcVde), .VtcVs(VtcVs), .pix_hit(pix_hit), .weight(weight),
        .center_h(center_h), .center_v(center_v), .center_valid(center_valid),
        .pixel_count(pixel_count), .overrun(overrun)
    );

    color_centroid_calc #(.MIN_PIXELS(1)) u_dut1 (
        .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .VtcVde(VtcVde), .VtcVs(VtcVs), .pix_hit(pix_hit), .weight(weight),
        .center_h(center_h1), .center_v(center_v1), .center_valid(center_valid1),
        .pixel_count(pixel_count1), .overrun(overrun1)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [11:0] h;
        logic [10:0] v;
        logic        valid;
        logic [23:0] cnt;
    } res_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    res_t sb[$];
    res_t sb1[$];
    res_t pr, pr1;
    longint unsigned m_sx = 0, m_sy = 0, m_cnt = 0;

    function automatic res_t predict(input res_t prev, input longint unsigned minp);
        res_t r;
        longint unsigned qx, qy;
        r.cnt = m_cnt[23:0];
        if (m_cnt < minp) begin
            r.h = prev.h;
            r.v = prev.v;
            r.valid = 1'b0;
        end else begin
            qx = m_sx / m_cnt;
            qy = m_sy / m_cnt;
            r.h = qx[11:0];
            r.v = qy[10:0];
            r.valid = 1'b1;
        end
        return r;
    endfunction

    task automatic reset_model();
        pr.h = 12'd160; pr.v = 11'd120; pr.valid = 1'b0; pr.cnt = '0;
        pr1 = pr;
        m_sx = 0; m_sy = 0; m_cnt = 0;
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_hit(input int unsigned x, input int unsigned y,
                           input int unsigned w, input bit modelled);
        longint unsigned eff;
        VtcHCnt = x[11:0];
        VtcVCnt = y[10:0];
        weight  = w[3:0];
        VtcVde  = 1'b1;
        pix_hit = 1'b1;
`ifdef WEIGHTED_CENTROID_EN
        eff = longint'(w[3:0]);
`else
        eff = 1;
`endif
        if (modelled) begin
            m_sx  += longint'(x) * eff;
            m_sy  += longint'(y) * eff;
            m_cnt += eff;
        end
    endtask

    task automatic clear_hit();
        VtcVde  = 1'b0;
        pix_hit = 1'b0;
    endtask

    task automatic hit(input int unsigned x, input int unsigned y, input int unsigned w);
        set_hit(x, y, w, 1'b1);
        tick();
        clear_hit();
    endtask

    // Frame end followed by the check of the published result at +66.
    task automatic frame_end_publish(input bit drop_hit);
        res_t e, e1;
        e  = predict(pr, 16);
        e1 = predict(pr1, 1);
        sb.push_back(e);
        sb1.push_back(e1);
        VtcVs = 1'b1;
        if (drop_hit) set_hit(999, 999, $urandom_range(1, 15), 1'b0);
        tick();
        clear_hit();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        for (int k = 1; k <= 65; k++) begin
            VtcVs = (k < 3);
            tick();
        end
        if (e.valid) begin
            total++;
            if ({center_h, center_v, center_valid, pixel_count} !== {pr.h, pr.v, pr.valid, pr.cnt}) begin
                bad++;
                $display("FAIL hold_at_65 got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d",
                         center_h, center_v, center_valid, pixel_count, pr.h, pr.v, pr.valid, pr.cnt);
            end
        end
        if (e1.valid) begin
            total++;
            if ({center_h1, center_v1, center_valid1, pixel_count1} !== {pr1.h, pr1.v, pr1.valid, pr1.cnt}) begin
                bad++;
                $display("FAIL hold1_at_65 got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d",
                         center_h1, center_v1, center_valid1, pixel_count1, pr1.h, pr1.v, pr1.valid, pr1.cnt);
            end
        end
        tick();
        e  = sb.pop_front();
        e1 = sb1.pop_front();
        total++; if (center_h !== e.h) begin bad++; $display("FAIL center_h got=%0d want=%0d", center_h, e.h); end
        total++; if (center_v !== e.v) begin bad++; $display("FAIL center_v got=%0d want=%0d", center_v, e.v); end
        total++; if (center_valid !== e.valid) begin bad++; $display("FAIL center_valid got=%0d want=%0d", center_valid, e.valid); end
        total++; if (pixel_count !== e.cnt) begin bad++; $display("FAIL pixel_count got=%0d want=%0d", pixel_count, e.cnt); end
        total++; if (center_h1 !== e1.h) begin bad++; $display("FAIL center_h_min1 got=%0d want=%0d", center_h1, e1.h); end
        total++; if (center_v1 !== e1.v) begin bad++; $display("FAIL center_v_min1 got=%0d want=%0d", center_v1, e1.v); end
        total++; if (center_valid1 !== e1.valid) begin bad++; $display("FAIL center_valid_min1 got=%0d want=%0d", center_valid1, e1.valid); end
        total++; if (pixel_count1 !== e1.cnt) begin bad++; $display("FAIL pixel_count_min1 got=%0d want=%0d", pixel_count1, e1.cnt); end
        pr  = e;
        pr1 = e1;
    endtask

    task automatic test_reset();
        reset_model();
        tick();
        tick();
        total++; if (center_h !== 12'd160) begin bad++; $display("FAIL rst_center_h got=%0d want=160", center_h); end
        total++; if (center_v !== 11'd120) begin bad++; $display("FAIL rst_center_v got=%0d want=120", center_v); end
        total++; if (center_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d want=0", center_valid); end
        total++; if (pixel_count !== 24'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", pixel_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0d want=0", overrun); end
        @(negedge PCLK);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_min1_basic();
        for (int i = 0; i < 4; i++) hit(100, 50, 1);
        frame_end_publish(1'b0);
    endtask

    task automatic test_rectangle();
        for (int y = 20; y <= 29; y++)
            for (int x = 10; x <= 19; x++)
                hit(x, y, 1);
        // hit flag outside active video must not count
        VtcVde = 1'b0; pix_hit = 1'b1; VtcHCnt = 12'd900; VtcVCnt = 11'd400;
        tick(); tick();
        clear_hit();
        frame_end_publish(1'b1);
    endtask

    task automatic test_below_min();
        for (int i = 0; i < 5; i++) hit(300, 200, 1);
        frame_end_publish(1'b0);
    endtask

    task automatic test_overrun();
        res_t e, e1;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre got=%0d want=0", overrun); end
        for (int i = 0; i < 20; i++) hit(40, 30, 1);
        e  = predict(pr, 16);
        e1 = predict(pr1, 1);
        sb.push_back(e);
        sb1.push_back(e1);
        VtcVs = 1'b1;
        tick();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        for (int k = 1; k <= 65; k++) begin
            VtcVs = (k == 1) || (k == 20) || (k == 21);
            if (k == 20) begin
                m_sx = 0; m_sy = 0; m_cnt = 0;
            end
            if (k >= 5 && k <= 15) set_hit(500, 400, 3, 1'b0);
            else if (k >= 25 && k <= 40) set_hit(3, 5, 1, 1'b1);
            else clear_hit();
            tick();
            if (k == 19) begin
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early got=%0d want=0", overrun); end
            end
            if (k == 20) begin
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%0d want=1", overrun); end
            end
        end
        clear_hit();
        total++;
        if ({center_h, center_v, center_valid} !== {pr.h, pr.v, pr.valid}) begin
            bad++;
            $display("FAIL overrun_hold got=%0d,%0d,%0d want=%0d,%0d,%0d",
                     center_h, center_v, center_valid, pr.h, pr.v, pr.valid);
        end
        tick();
        e  = sb.pop_front();
        e1 = sb1.pop_front();
        total++; if (center_h !== e.h) begin bad++; $display("FAIL ovr_center_h got=%0d want=%0d", center_h, e.h); end
        total++; if (center_v !== e.v) begin bad++; $display("FAIL ovr_center_v got=%0d want=%0d", center_v, e.v); end
        total++; if (pixel_count !== e.cnt) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", pixel_count, e.cnt); end
        total++; if (center_valid1 !== e1.valid) begin bad++; $display("FAIL ovr_valid_min1 got=%0d want=%0d", center_valid1, e1.valid); end
        pr  = e;
        pr1 = e1;
        // The 16 hits after the second edge form the next frame
        frame_end_publish(1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%0d want=1", overrun); end
    endtask

    task automatic test_reset_mid_div();
        for (int i = 0; i < 20; i++) hit(50, 60, 1);
        VtcVs = 1'b1;
        tick();
        for (int k = 1; k <= 45; k++) begin
            VtcVs = (k < 3);
            tick();
        end
        #2;
        RST_N = 1'b0;
        #1;
        reset_model();
        total++; if (center_h !== 12'd160) begin bad++; $display("FAIL mid_rst_h got=%0d want=160", center_h); end
        total++; if (center_v !== 11'd120) begin bad++; $display("FAIL mid_rst_v got=%0d want=120", center_v); end
        total++; if (center_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0d want=0", center_valid); end
        total++; if (pixel_count !== 24'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", pixel_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_overrun got=%0d want=0", overrun); end
        total++; if (center_valid1 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid_min1 got=%0d want=0", center_valid1); end
        tick();
        tick();
        @(negedge PCLK);
        RST_N = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        total++;
        if ({center_h1, center_v1, center_valid1} !== {12'd160, 11'd120, 1'b0}) begin
            bad++;
            $display("FAIL no_partial got=%0d,%0d,%0d want=160,120,0", center_h1, center_v1, center_valid1);
        end
        for (int i = 0; i < 100; i++) hit(7, 9, 1);
        frame_end_publish(1'b0);
    endtask

`ifdef WEIGHTED_CENTROID_EN
    task automatic test_weighted();
        hit(0, 0, 1);
        hit(30, 3, 2);
        hit(600, 400, 0);
        frame_end_publish(1'b0);
    endtask
`else
    task automatic test_weight_ignored();
        hit(0, 0, 0);
        hit(30, 3, 15);
        frame_end_publish(1'b0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_min1_basic();
        test_rectangle();
        test_below_min();
        test_overrun();
        test_reset_mid_div();
`ifdef WEIGHTED_CENTROID_EN
        test_weighted();
`else
        test_weight_ignored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_centroid_calc.md
Name: color_centroid_calc

Overview:
- Computes the centre of detected-colour pixels once per video frame.
- Each cycle, accumulates the coordinates of pixels flagged as hits during active video.
- At frame end, divides the accumulated sums by the hit count with a serial divider.
- Publishes center_h/center_v, which drive the weighting and tracking logic downstream.

Parameters:
- SUM_W, 32, width of the coordinate-sum accumulators and of the divider datapath.
- CNT_W, 24, width of the hit-count / weight-sum accumulator.
- MIN_PIXELS, 16, minimum accumulated count for a frame to produce a valid centre.
- CENTER_H_RST, 160, center_h value after reset.
- CENTER_V_RST, 120, center_v value after reset.

Ports:
- PCLK  input  1  pixel clock; the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- VtcHCnt  input  12  current pixel x coordinate.
- VtcVCnt  input  11  current pixel y coordinate.
- VtcVde  input  1  active-video qualifier.
- VtcVs  input  1  vertical sync, active high.
- pix_hit  input  1  current pixel matches the target colour.
- weight  input  4  pixel weight; used only when the optional feature is compiled in.
- center_h  output  12  centroid x, registered.
- center_v  output  11  centroid y, registered.
- center_valid  output  1  last completed frame met MIN_PIXELS.
- pixel_count  output  CNT_W  accumulated count (or weight sum) of the last completed frame.
- overrun  output  1  sticky; set when a frame end arrives while the divider is busy.

Behaviour:
- Reset values: center_h=CENTER_H_RST, center_v=CENTER_V_RST, center_valid=0, pixel_count=0, overrun=0. All accumulators cleared, FSM in ACCUM. Reset may assert at any time, including mid-division; no partial result is ever published.
- Accumulation:
  - Applies on every cycle with VtcVde=1 and pix_hit=1, using effective weight w.
  - sum_x += VtcHCnt*w, sum_y += VtcVCnt*w, cnt += w.
  - w=1 when the optional feature is absent.
  - Sums wrap modulo 2^SUM_W; the defaults cover 640x480 with w up to 15 without overflow.
- Frame end: a rising edge of VtcVs, detected on a registered copy of VtcVs. On the detection cycle:
  - sum_x, sum_y and cnt are snapshotted.
  - The live accumulators are cleared. A hit on that same cycle is dropped and does not go into the new frame.
- FSM states:
  - ACCUM: on frame end, go to CHECK.
  - CHECK, one cycle:
    - If snap_cnt < MIN_PIXELS: set center_valid=0, update pixel_count, hold center_h/center_v, return to ACCUM.
    - Otherwise go to DIV_X.
  - DIV_X: restoring divider, one quotient bit per cycle, SUM_W cycles, computes snap_x/snap_cnt. Quotient truncates toward zero.
  - DIV_Y: same divider for snap_y/snap_cnt, SUM_W cycles.
  - UPDATE, one cycle:
    - center_h = quotient_x[11:0], center_v = quotient_y[10:0].
    - center_valid=1, pixel_count=snap_cnt.
    - Return to ACCUM.
- Latency: outputs change on cycle N+2*SUM_W+2, where N is the frame-end detection cycle (66 cycles with defaults). Outputs are stable at all other times.
- Accumulation into the live registers continues during CHECK, DIV_X, DIV_Y and UPDATE.
- Frame end while not in ACCUM:
  - The live accumulators are cleared; that frame's data is discarded.
  - overrun is set and stays set until reset.
  - The division in progress completes unaffected.
- snap_cnt=0 always takes the MIN_PIXELS path, so the divider never sees a zero divisor. MIN_PIXELS=0 is illegal.

Optional Feature:
- Macro: WEIGHTED_CENTROID_EN.
- When defined, w = weight input, so sums are weight-scaled and cnt is the weight sum. Pixels with weight=0 contribute nothing.
- When undefined, the weight port is present but ignored, and w=1 for every hit pixel.

Test Plan:
- Reset released, 4 hits with MIN_PIXELS=1 at (100,50): center_h=100, center_v=50 and center_valid=1 exactly 66 cycles after the VtcVs rise is detected.
- Hits on the rectangle x=10..19, y=20..29 (100 pixels), then VtcVs rise: pixel_count=100, center_h=14 (1450/100 truncated), center_v=24.
- Frame with 5 hits (below MIN_PIXELS=16): center_valid=0, pixel_count=5, center_h/center_v keep their previous values.
- Second VtcVs rise 20 cycles after the first: overrun=1, first result still published at +66, hits between the two edges discarded.
- RST_N low during DIV_Y: all outputs return to reset values immediately; next frame of 100 hits at (7,9) gives center (7,9).
- With WEIGHTED_CENTROID_EN: hit (0,0) w=1 and hit (30,3) w=2, MIN_PIXELS=1: center_h=20, center_v=2, pixel_count=3.
